// File: rtl/ps2_hex_entry_if.sv
// PS/2 receive pins and hex-entry results bundled for ps2_hex_entry.
// The device/bench side drives the PS/2 pins; the block drives the results.
interface ps2_hex_entry_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] entry;
    logic [3:0]  digit_cnt;
    logic [31:0] value;
    logic        value_valid;
    logic        frame_err;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output entry,
        output digit_cnt,
        output value,
        output value_valid,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  entry,
        input  digit_cnt,
        input  value,
        input  value_valid,
        input  frame_err
    );
endinterface

// File: rtl/ps2_hex_entry.sv
// PS/2 device-to-host frame receiver with Set-2 scancode decoding into a
// 32-bit hex entry register; Enter commits the entry as an operand.
module ps2_hex_entry #(
    parameter int unsigned FREQ_IN = 100000000,
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 100000
) (
    input logic            clk,
    input logic            rst,
    ps2_hex_entry_if.slave bus
);

    localparam int unsigned FltW = $clog2(FILTER + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
    localparam logic [FltW-1:0] FltLast = FltW'(FILTER - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT - 1);

    // The system clock must comfortably outrun the ~17 kHz PS/2 bit clock.
    if (FREQ_IN < 100000 || FILTER < 1 || TIMEOUT < 2) begin : gen_bad_cfg
        $error("ps2_hex_entry: unsupported FREQ_IN/FILTER/TIMEOUT");
    end

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            filt_q;
    logic [FltW-1:0] flt_cnt_q;
    logic            fall_q, bit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[0], bus.ps2_data};
            bit_q       <= data_sync_q[1];
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FltLast) begin
                filt_q    <= clk_sync_q[1];
                flt_cnt_q <= '0;
                fall_q    <= filt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    state_e         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q, byte_q;
    logic           par_q, byte_rdy_q, frame_err_q;
    logic [ToW-1:0] to_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            par_q       <= 1'b0;
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == StIdle || fall_q) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (fall_q) begin
                case (state_q)
                    StIdle: begin
                        if (!bit_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {bit_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_q <= StParity;
                    end
                    StParity: begin
                        par_q   <= bit_q;
                        state_q <= StStop;
                    end
                    default: begin
                        state_q <= StIdle;
                        if (bit_q && (^{shift_q, par_q})) begin
                            byte_rdy_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (state_q != StIdle && to_cnt_q == ToLast) begin
                state_q     <= StIdle;
                frame_err_q <= 1'b1;
            end
        end
    end

    logic       is_digit;
    logic [3:0] digit;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'h0;
        case (byte_q)
            8'h45: digit = 4'h0;
            8'h16: digit = 4'h1;
            8'h1E: digit = 4'h2;
            8'h26: digit = 4'h3;
            8'h25: digit = 4'h4;
            8'h2E: digit = 4'h5;
            8'h36: digit = 4'h6;
            8'h3D: digit = 4'h7;
            8'h3E: digit = 4'h8;
            8'h46: digit = 4'h9;
            8'h1C: digit = 4'hA;
            8'h32: digit = 4'hB;
            8'h21: digit = 4'hC;
            8'h23: digit = 4'hD;
            8'h24: digit = 4'hE;
            8'h2B: digit = 4'hF;
            default: is_digit = 1'b0;
        endcase
    end

    logic        brk_q, brk_d, ext_q, ext_d, vv_q, vv_d;
    logic [31:0] entry_q, entry_d, value_q, value_d;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        vv_d    = 1'b0;
        if (byte_rdy_q) begin
            if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                // Release or extended key: swallow the code and rearm.
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (is_digit) begin
                if (cnt_q < 4'd8) begin
                    entry_d = {entry_q[27:0], digit};
                    cnt_d   = cnt_q + 4'd1;
                end
            end else if (byte_q == 8'h66) begin
                if (cnt_q != 4'd0) begin
                    entry_d = {4'h0, entry_q[31:4]};
                    cnt_d   = cnt_q - 4'd1;
                end
            end else if (byte_q == 8'h5A) begin
                value_d = entry_q;
                vv_d    = 1'b1;
                entry_d = '0;
                cnt_d   = '0;
            end else if (byte_q == 8'h76) begin
                entry_d = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            entry_q <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            vv_q    <= 1'b0;
        end else begin
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            vv_q    <= vv_d;
        end
    end

    assign bus.entry       = entry_q;
    assign bus.digit_cnt   = cnt_q;
    assign bus.value       = value_q;
    assign bus.value_valid = vv_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: doc/ps2_hex_entry.md
# ps2_hex_entry

PS/2 keyboard receiver and hexadecimal operand-entry block for the ALU lab board. It deserialises PS/2 device-to-host frames and decodes Set-2 scancodes into hex digits. Digits are shifted into a live 32-bit entry register, which the seven-segment scanner can display, and Enter commits the entry as an operand. This is the input counterpart of the display path: the display path shows a 32-bit value as 8 hex digits, and this block builds a 32-bit value from typed hex digits.

## Interface
- FREQ_IN, 100000000: system clock frequency in Hz.
- FILTER, 8: number of consecutive `clk` cycles a synchronised `ps2_clk` level must hold before the filtered clock changes.
- TIMEOUT, 100000: `clk` cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 100 MHz).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the device; asynchronous to `clk`.
- ps2_data  in  1  raw PS/2 data from the device; asynchronous to `clk`.
- entry  out  32  live entry register: last typed digit in [3:0].
- digit_cnt  out  4  number of digits in `entry`, range 0..8.
- value  out  32  operand latched on Enter.
- value_valid  out  1  one-cycle pulse when `value` updates.
- frame_err  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - The synchronised `ps2_clk` drives a FILTER-cycle glitch filter.
  - A falling edge of the filtered clock is a one-cycle `fall` strobe, and `ps2_data` is sampled on that strobe.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. If data=1, stay in IDLE; this is not an error.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: on `fall`, return to IDLE. If stop=1 and the parity is odd over data plus parity bit, emit a `byte_rdy` strobe with the byte. Otherwise pulse `frame_err` and discard the byte.
  - Timeout: a counter runs in every state except IDLE and resets on each `fall`. When it reaches TIMEOUT-1, the FSM goes to IDLE and pulses `frame_err`.
- **Scancode decoder**, acting on `byte_rdy` and holding flags `brk` and `ext`:
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Any other byte with `brk` or `ext` set is ignored, and both flags are cleared.
  - Otherwise the byte is a plain make code:
    - Digits 0..9 are 45,16,1E,26,25,2E,36,3D,3E,46.
    - Digits A..F are 1C,32,21,23,24,2B.
    - Digit: if `digit_cnt` is below 8, `entry` becomes `{entry[27:0], d}` and `digit_cnt` increments. At 8 the digit is ignored; there is no wrap.
    - Backspace (0x66): if `digit_cnt` is above 0, `entry` becomes `{4'h0, entry[31:4]}` and `digit_cnt` decrements. At 0 there is no effect.
    - Enter (0x5A): `value` becomes `entry` and `value_valid` pulses. In the same cycle `entry` and `digit_cnt` clear to 0. Enter with 0 digits commits 0.
    - Esc (0x76): `entry` and `digit_cnt` clear to 0, and `value` is unchanged.
    - All other codes are ignored.
- **Reset**: all outputs are 0, the FSM is in IDLE, `brk`=`ext`=0 and the counters are 0. Synchroniser and filter state reset high, which is the idle bus level. Reset asserted mid-frame discards the partial frame without pulsing `frame_err`.

## Timing
- `byte_rdy` is asserted in the cycle after the `fall` that samples the stop bit.
- `entry`, `digit_cnt`, `value` and `value_valid` update on the clock edge that ends the `byte_rdy` cycle. They are therefore visible 2 cycles after the stop-bit `fall`.
- Raw `ps2_clk` falling edge to `fall`: 2 cycles for the synchroniser plus FILTER cycles.
- `value_valid` and `frame_err` are high for exactly one `clk` cycle. They never fire in the same cycle, because they come from different bytes.
- A new start bit may be accepted on the first `fall` after returning to IDLE; back-to-back frames are lossless.
- A glitch on `ps2_clk` shorter than FILTER cycles produces no `fall`.
- `ps2_data` is never driven: this block is receive-only, and host-to-device inhibit is not supported.

## Test plan
- **Single digit:** send a frame for 0x16, then the frames F0 and 16 (the key release). Required: `entry`=0x00000001, `digit_cnt`=1, no `value_valid`, no `frame_err`.
- **Full entry and commit:** type 1,2,3,4,A,B,C,D then a 9th digit F, then Enter. Required: `entry`=0x1234ABCD before Enter, with the F ignored. After Enter, `value`=0x1234ABCD, `value_valid` is high for 1 cycle, and `entry`=0 with `digit_cnt`=0.
- **Edit keys:** type 7, 8, Backspace, 9, Enter. Required: `value`=0x00000079. Then type 5 and Esc: `entry`=0, `value` stays 0x00000079.
- **Extended code:** send E0 5A, then E0 F0 5A. Required: no commit, no `entry` change, no error.
- **Bad frames:**
  - A frame with even parity: `frame_err` pulses and `entry` is unchanged.
  - A frame with stop=0: `frame_err` pulses.
  - A frame stopped after 5 bits: `frame_err` pulses once, TIMEOUT cycles after the last `fall`. A following good 0x45 frame then yields `entry` low nibble 0.
- **Glitch and reset:** a 3-cycle low pulse on `ps2_clk` produces no bit. Asserting `rst` mid-frame clears every output to 0, and a subsequent clean frame decodes correctly.
